// File: rtl/bcd_scan_counter_if.sv
// Bundle of the control/data signals of the BCD scan counter.
// master drives the controls and observes the outputs; slave is the counter itself.
interface bcd_scan_counter_if;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic        cnt_en;
  logic [15:0] count;
  logic        carry;
  logic        load_err;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;

  modport master (
    output clr, load, load_val, cnt_en,
    input  count, carry, load_err, bcd_out, an_n
  );

  modport slave (
    input  clr, load, load_val, cnt_en,
    output count, carry, load_err, bcd_out, an_n
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up-counter with load/clear and a time-multiplexed digit scanner.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_BLANK_EN.
module bcd_scan_counter #(
  parameter int SCAN_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_scan_counter_if.slave   bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_digit;
  logic [15:0]   r_count;
  logic          r_carry;
  logic          r_load_err;
  logic [3:0]    r_bcd;
  logic [3:0]    r_an_n;

  logic [15:0]   w_inc;
  logic          w_wrap;
  logic [15:0]   w_load;
  logic          w_load_bad;
  logic [3:0]    w_scan_digit;
  logic [3:0]    w_an_next;
  logic          w_slot_end;

  // Ripple increment: a digit advances only while every lower digit was 9.
  always_comb begin
    logic w_chain;
    logic [3:0] w_d;
    w_inc   = r_count;
    w_chain = 1'b1;
    w_d     = 4'd0;
    for (int k = 0; k < 4; k++) begin
      w_d = r_count[4*k +: 4];
      if (w_chain) begin
        if (w_d == 4'd9) begin
          w_inc[4*k +: 4] = 4'd0;
        end else begin
          w_inc[4*k +: 4] = w_d + 4'd1;
          w_chain         = 1'b0;
        end
      end
    end
    w_wrap = w_chain;
  end

  always_comb begin
    w_load     = bus.load_val;
    w_load_bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.load_val[4*k +: 4] > 4'd9) begin
        w_load[4*k +: 4] = 4'd0;
        w_load_bad       = 1'b1;
      end
    end
  end

  always_comb begin
    w_scan_digit = r_count[3:0];
    case (r_digit)
      2'd0: w_scan_digit = r_count[3:0];
      2'd1: w_scan_digit = r_count[7:4];
      2'd2: w_scan_digit = r_count[11:8];
      2'd3: w_scan_digit = r_count[15:12];
      default: w_scan_digit = r_count[3:0];
    endcase
  end

`ifdef BCD_SCAN_BLANK_EN
  // A digit is dark when it and every digit above it are zero; digit 0 always shows.
  logic [3:0] w_lead_zero;
  assign w_lead_zero = {r_count[15:12] == 4'd0,
                        r_count[15:8]  == 8'd0,
                        r_count[15:4]  == 12'd0,
                        1'b0};
  assign w_an_next = ((r_presc == '0) || w_lead_zero[r_digit]) ? 4'b1111
                                                                : ~(4'b0001 << r_digit);
`else
  assign w_an_next = (r_presc == '0) ? 4'b1111 : ~(4'b0001 << r_digit);
`endif

  assign w_slot_end = (r_presc == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= 16'h0000;
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
      r_presc    <= '0;
      r_digit    <= 2'd0;
      r_bcd      <= 4'd0;
      r_an_n     <= 4'b1111;
    end else begin
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
      if (bus.clr) begin
        r_count <= 16'h0000;
      end else if (bus.load) begin
        r_count    <= w_load;
        r_load_err <= w_load_bad;
      end else if (bus.cnt_en) begin
        r_count <= w_inc;
        r_carry <= w_wrap;
      end

      // Scanner free-runs; outputs reflect the pre-edge prescaler, digit and count.
      r_bcd  <= w_scan_digit;
      r_an_n <= w_an_next;
      if (w_slot_end) begin
        r_presc <= '0;
        r_digit <= r_digit + 2'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign bus.count    = r_count;
  assign bus.carry    = r_carry;
  assign bus.load_err = r_load_err;
  assign bus.bcd_out  = r_bcd;
  assign bus.an_n     = r_an_n;

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Four-digit BCD up-counter (0000–9999) with a time-multiplexed digit scanner. It sits directly upstream of the BCD-to-7-segment decoder. Each scan slot it presents one digit's 4-bit BCD code on `bcd_out` for the decoder, plus an active-low digit enable on `an_n` for the common-anode display. It also provides load/clear control and a wrap carry for cascading.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clock cycles per digit slot; legal range ≥ 2.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `clr`  in  1  — synchronous clear of the count to 0000.
- `load`  in  1  — synchronous load of `load_val`.
- `load_val`  in  16  — four BCD digits; [3:0] is digit 0 (ones), [15:12] is digit 3 (thousands).
- `cnt_en`  in  1  — increment the count by 1 this cycle.
- `count`  out  16  — current count as four BCD digits, same packing as `load_val`.
- `carry`  out  1  — one-cycle pulse when the count wraps 9999→0000.
- `load_err`  out  1  — one-cycle pulse when a loaded nibble was >9.
- `bcd_out`  out  4  — BCD code of the digit being scanned; feeds the decoder.
- `an_n`  out  4  — active-low digit enable; bit i drives digit i.

## Operation
- Control priority: `rst_n`=0, then `clr`, then `load`, then `cnt_en`. Only the highest-priority active action takes effect in a cycle.
- Reset, applied at the edge with `rst_n`=0:
  - `count`=0000, `carry`=0, `load_err`=0, `bcd_out`=0, `an_n`=4'b1111.
  - Prescaler p=0, digit index i=0.
- Clear: `count`←0000; `carry`=0; `load_err`=0.
- Load:
  - Each nibble ≤9 is loaded as-is.
  - Each nibble >9 is loaded as 0.
  - `load_err`=1 next cycle if any nibble was >9; otherwise 0.
  - `carry`=0.
- Increment: ripple BCD add.
  - Digit k rolls 9→0 and increments digit k+1 only when all lower digits were 9.
  - At 9999 the count goes to 0000 and `carry`=1 for exactly that cycle.
  - Otherwise `carry`=0.
- Hold: if no action is active, `count` holds and `carry`/`load_err` are 0.
- Scanner (free-running, independent of `cnt_en`/`clr`/`load`):
  - If p=SCAN_DIV−1: p←0 and i←(i+1) mod 4.
  - Otherwise p←p+1.
  - Digit order: 0,1,2,3,0,…
- Scanner outputs are registered from the current state (p, i, `count`):
  - `bcd_out` ← `count`[4i+3:4i].
  - `an_n` ← 4'b1111 when p=0 (anti-ghosting blank slot); otherwise only bit i low.
- A count change during a slot is visible on `bcd_out` one cycle later. The slot is not restarted.
- Reset mid-slot: the scanner restarts at digit 0 with p=0. The first enabled digit after reset is digit 0.

## Timing
- `count`, `carry`, `load_err`: update on the edge where the action is sampled (one-cycle latency from input to output).
- `bcd_out`/`an_n` for cycle t+1 reflect p, i and `count` at cycle t.
- Each digit is enabled for SCAN_DIV−1 cycles, then blanked for 1 cycle.
- Full frame: 4·SCAN_DIV cycles.
- After reset release, the first low `an_n` appears two edges later: `an_n`=4'b1110, `bcd_out`=digit 0.
- `cnt_en` held high increments every cycle; there is no back-pressure.
- `clr` and `load` asserted together: `clr` wins and `load_err` stays 0.

## Configuration
- `BCD_SCAN_BLANK_EN` (leading-zero blanking):
  - Defined: digit i (i≥1) keeps `an_n`[i]=1 for its whole slot when digits i..3 are all 0. Digit 0 is never blanked, so 0000 shows a single "0". `bcd_out` is unchanged.
  - Undefined: all four digits are enabled every frame.

## Test plan
- Reset then scan, SCAN_DIV=4, `count`=0000: `an_n` sequence 1111,1110,1110,1110,1111,1101,1101,1101,…; `bcd_out`=0 throughout.
- Load 16'h1234, SCAN_DIV=4: `bcd_out` is 4,3,2,1 in digit slots 0..3; `load_err`=0.
- Load 16'h9998, `cnt_en` for 2 cycles: `count` is 9999 then 0000; `carry`=1 only on the 0000 cycle.
- Load 16'h1A2F: `count`=1020 and `load_err` pulses for one cycle. The same cycle with `clr`=1 instead gives `count`=0000 and `load_err`=0.
- Apply `rst_n`=0 mid-slot at digit 2 with `count`=0555: next cycle all outputs are at reset values; the scan resumes from digit 0.
- `BCD_SCAN_BLANK_EN` defined, `count`=0042: digits 2 and 3 keep `an_n` high for their full slots; 0000 enables digit 0 only.
